// File: rtl/cp_remove_if.sv
`default_nettype none
// ============================================================================
// cp_remove_if : AXI-Stream bundle used on both sides of cp_remove.
// Rev 1.0 - initial release
// ============================================================================
interface cp_remove_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

`ifdef CP_REMOVE_FRAME_CHECK_EN
    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
`else
    // Input framing is derived from counters, so the slave side ignores tlast.
    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
`endif
endinterface
`default_nettype wire

// File: rtl/cp_remove.sv
`default_nettype none
// ============================================================================
// cp_remove : strips the cyclic prefix of every OFDM symbol and forwards
//             2^nfft samples per symbol with tlast on the final sample.
// Optional input framing check enabled by defining CP_REMOVE_FRAME_CHECK_EN.
// Rev 1.0 - initial release
// ============================================================================
module cp_remove #(
    parameter int DATA_W        = 32,
    parameter int NFFT_LOG2_MAX = 13,
    parameter int CP_W          = 16,
    parameter int SYM_W         = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              config_start,
    input  logic [4:0]        nfft,
    input  logic [CP_W-1:0]   cp_len,
    input  logic [SYM_W-1:0]  symbols,
    input  logic              continuous,
    cp_remove_if.slave        s_axis,
    cp_remove_if.master       m_axis,
    output logic              busy,
    output logic              done,
`ifdef CP_REMOVE_FRAME_CHECK_EN
    output logic              frame_err,
`endif
    output logic [SYM_W-1:0]  sym_count
);
    localparam int CNT_W = NFFT_LOG2_MAX + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SKIP  = 2'd1,
        S_PASS  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic                cfg_prev_q,  cfg_prev_d;
    logic [4:0]          nfft_q,      nfft_d;
    logic [CP_W-1:0]     cp_len_q,    cp_len_d;
    logic [SYM_W-1:0]    symbols_q,   symbols_d;
    logic                cont_q,      cont_d;
    logic [CP_W-1:0]     cp_cnt_q,    cp_cnt_d;
    logic [CNT_W-1:0]    smp_cnt_q,   smp_cnt_d;
    logic [DATA_W-1:0]   m_data_q,    m_data_d;
    logic                m_valid_q,   m_valid_d;
    logic                m_last_q,    m_last_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic [SYM_W-1:0]    sym_count_q, sym_count_d;
`ifdef CP_REMOVE_FRAME_CHECK_EN
    logic                frame_err_q, frame_err_d;
    logic                m_trunc_q,   m_trunc_d;
`endif

    logic                s_ready;
    logic                in_hs;
    logic                out_hs;
    logic                tl_w;
    logic                trunc_w;
    logic                pass_last;
    logic                limit_hit;
    logic [CNT_W-1:0]    last_idx;
    state_t              next_blk;

    always_comb begin
        case (state_q)
            S_SKIP:  s_ready = 1'b1;
            S_PASS:  s_ready = !m_valid_q || m_axis.tready;
            default: s_ready = 1'b0;
        endcase
    end

`ifdef CP_REMOVE_FRAME_CHECK_EN
    assign tl_w    = s_axis.tlast;
    assign trunc_w = m_trunc_q;
`else
    assign tl_w    = 1'b0;
    assign trunc_w = 1'b0;
`endif

    assign in_hs     = s_axis.tvalid && s_ready;
    assign out_hs    = m_valid_q && m_axis.tready;
    assign last_idx  = (CNT_W'(1) << nfft_q) - CNT_W'(1);
    assign pass_last = (smp_cnt_q == last_idx);
    assign next_blk  = (cp_len_q == '0) ? S_PASS : S_SKIP;
    // The previous symbol's last beat has always left by now, so +1 counts the current one.
    assign limit_hit = !cont_q && (symbols_q != '0) &&
                       (({1'b0, sym_count_q} + (SYM_W+1)'(1)) == {1'b0, symbols_q});

    always_comb begin
        state_d     = state_q;
        cfg_prev_d  = config_start;
        nfft_d      = nfft_q;
        cp_len_d    = cp_len_q;
        symbols_d   = symbols_q;
        cont_d      = cont_q;
        cp_cnt_d    = cp_cnt_q;
        smp_cnt_d   = smp_cnt_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        done_d      = 1'b0;
        sym_count_d = sym_count_q;
`ifdef CP_REMOVE_FRAME_CHECK_EN
        frame_err_d = frame_err_q;
        m_trunc_d   = m_trunc_q;
`endif

        if (out_hs) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            if (m_last_q && !trunc_w && (sym_count_q != {SYM_W{1'b1}})) begin
                sym_count_d = sym_count_q + SYM_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (config_start && !cfg_prev_q) begin
                    nfft_d      = nfft;
                    cp_len_d    = cp_len;
                    symbols_d   = symbols;
                    cont_d      = continuous;
                    sym_count_d = '0;
                    cp_cnt_d    = '0;
                    smp_cnt_d   = '0;
`ifdef CP_REMOVE_FRAME_CHECK_EN
                    frame_err_d = 1'b0;
`endif
                    state_d     = (cp_len == '0) ? S_PASS : S_SKIP;
                end
            end
            S_SKIP: begin
                if (in_hs) begin
                    if (tl_w) begin
                        // A block boundary inside the prefix restarts the prefix count.
                        cp_cnt_d = '0;
`ifdef CP_REMOVE_FRAME_CHECK_EN
                        frame_err_d = 1'b1;
`endif
                    end else if (cp_cnt_q == (cp_len_q - CP_W'(1))) begin
                        cp_cnt_d = '0;
                        state_d  = S_PASS;
                    end else begin
                        cp_cnt_d = cp_cnt_q + CP_W'(1);
                    end
                end
            end
            S_PASS: begin
                if (in_hs) begin
                    m_data_d  = s_axis.tdata;
                    m_valid_d = 1'b1;
                    m_last_d  = pass_last || tl_w;
                    smp_cnt_d = smp_cnt_q + CNT_W'(1);
`ifdef CP_REMOVE_FRAME_CHECK_EN
                    m_trunc_d = tl_w && !pass_last;
                    if (tl_w != pass_last) begin
                        frame_err_d = 1'b1;
                    end
`endif
                    if (pass_last) begin
                        smp_cnt_d = '0;
                        state_d   = limit_hit ? S_DRAIN : next_blk;
                    end else if (tl_w) begin
                        smp_cnt_d = '0;
                        state_d   = next_blk;
                    end
                end
            end
            S_DRAIN: begin
                if (!m_valid_q || m_axis.tready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            cfg_prev_q  <= 1'b0;
            nfft_q      <= '0;
            cp_len_q    <= '0;
            symbols_q   <= '0;
            cont_q      <= 1'b0;
            cp_cnt_q    <= '0;
            smp_cnt_q   <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sym_count_q <= '0;
`ifdef CP_REMOVE_FRAME_CHECK_EN
            frame_err_q <= 1'b0;
            m_trunc_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cfg_prev_q  <= cfg_prev_d;
            nfft_q      <= nfft_d;
            cp_len_q    <= cp_len_d;
            symbols_q   <= symbols_d;
            cont_q      <= cont_d;
            cp_cnt_q    <= cp_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sym_count_q <= sym_count_d;
`ifdef CP_REMOVE_FRAME_CHECK_EN
            frame_err_q <= frame_err_d;
            m_trunc_q   <= m_trunc_d;
`endif
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign sym_count     = sym_count_q;
`ifdef CP_REMOVE_FRAME_CHECK_EN
    assign frame_err     = frame_err_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_cp_remove.sv
`default_nettype none
// ============================================================================
// tb_cp_remove : randomized self-checking bench for cp_remove against a
//                block-level (prefix / symbol) reference model.
// Rev 1.0 - initial release
// ============================================================================
module tb_cp_remove;
    localparam int DATA_W = 32;
    localparam int CP_W   = 16;
    localparam int SYM_W  = 32;

    logic             aclk         = 1'b0;
    logic             aresetn      = 1'b1;
    logic             config_start = 1'b0;
    logic [4:0]       nfft         = '0;
    logic [CP_W-1:0]  cp_len       = '0;
    logic [SYM_W-1:0] symbols      = '0;
    logic             continuous   = 1'b0;
    logic             busy;
    logic             done;
    logic [SYM_W-1:0] sym_count;
`ifdef CP_REMOVE_FRAME_CHECK_EN
    logic             frame_err;
`endif

    cp_remove_if #(.DATA_W(DATA_W)) s_if ();
    cp_remove_if #(.DATA_W(DATA_W)) m_if ();

    cp_remove #(
        .DATA_W        (DATA_W),
        .NFFT_LOG2_MAX (13),
        .CP_W          (CP_W),
        .SYM_W         (SYM_W)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .config_start (config_start),
        .nfft         (nfft),
        .cp_len       (cp_len),
        .symbols      (symbols),
        .continuous   (continuous),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .busy         (busy),
        .done         (done),
`ifdef CP_REMOVE_FRAME_CHECK_EN
        .frame_err    (frame_err),
`endif
        .sym_count    (sym_count)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    int cyc = 0, next_val = 0, in_cnt = 0, out_cnt = 0;
    int last_out_cyc = -1, done_cnt = 0, done_cyc = -1;
    int in_limit = 0, vprob = 100, rprob = 100, blk = 1, early_tl = -1, run_tag = 0;
    bit toggle_cfg = 1'b0, prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [DATA_W-1:0] exp_d[$];
    bit                exp_l[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] dat(input int v);
        logic [31:0] t;
        t = v;
        return {run_tag[7:0], t[23:0]};
    endfunction

    function automatic bit tl_of(input int v);
        if (early_tl >= 0) return v == early_tl;
        return (v % blk) == (blk - 1);
    endfunction

    // One clock: sample/check on negedge, drive new stimulus 1 time unit after posedge.
    task automatic step();
        logic              hs_in;
        logic [DATA_W-1:0] e;
        bit                l;
        @(negedge aclk);
        cyc++;
        if (prev_stall) check("hold_data", 64'(m_if.tdata), 64'(prev_data));
        if (m_if.tvalid && m_if.tready) begin
            if (exp_d.size() == 0) begin
                check("extra_beat", 64'(exp_d.size()), 64'd1);
            end else begin
                e = exp_d.pop_front();
                l = exp_l.pop_front();
                check("out_data", 64'(m_if.tdata), 64'(e));
                check("out_last", 64'(m_if.tlast), 64'(l));
            end
            out_cnt++;
            last_out_cyc = cyc;
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_data  = m_if.tdata;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_at_done", 64'(busy), 64'd0);
        end
        hs_in = s_if.tvalid && s_if.tready;
        @(posedge aclk);
        #1;
        if (hs_in) begin
            next_val++;
            in_cnt++;
        end
        if (!s_if.tvalid || hs_in)
            s_if.tvalid = (next_val < in_limit) && ($urandom_range(99) < vprob);
        s_if.tdata = dat(next_val);
        s_if.tlast = tl_of(next_val);
        if (rprob < 0) m_if.tready = ~m_if.tready;
        else           m_if.tready = ($urandom_range(99) < rprob);
        if (toggle_cfg) begin
            config_start = $urandom_range(1);
            nfft         = 5'($urandom_range(1, 13));
            cp_len       = CP_W'($urandom);
            symbols      = SYM_W'($urandom);
            continuous   = $urandom_range(1);
        end else begin
            config_start = 1'b0;
        end
    endtask

    task automatic do_reset();
        in_limit     = 0;
        toggle_cfg   = 1'b0;
        config_start = 1'b0;
        s_if.tvalid  = 1'b0;
        aresetn      = 1'b0;
        #2;
        check("rst_m_valid",   64'(m_if.tvalid), 64'd0);
        check("rst_m_data",    64'(m_if.tdata),  64'd0);
        check("rst_m_last",    64'(m_if.tlast),  64'd0);
        check("rst_s_ready",   64'(s_if.tready), 64'd0);
        check("rst_busy",      64'(busy),        64'd0);
        check("rst_done",      64'(done),        64'd0);
        check("rst_sym_count", 64'(sym_count),   64'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    // Model: each block is cp discarded samples then N forwarded ones; an input tlast
    // inside the prefix restarts the block, inside the payload ends the symbol early.
    task automatic run_stream(input int n, input int cp, input int syms, input bit cont,
                              input int lim, input int vp, input int rp,
                              input int abort_at, input int etl);
        int N, v, pos, full, idx, budget;
        bit finite, tl, ok;
        N        = 1 << n;
        blk      = cp + N;
        early_tl = etl;
        run_tag++;
        finite   = !cont && (syms != 0);
        exp_d.delete();
        exp_l.delete();
        v = 0; pos = 0; full = 0;
        while (finite ? (full < syms) : (v < lim)) begin
            tl = (v == etl);
            if (pos < cp) begin
                pos = tl ? 0 : pos + 1;
            end else begin
                idx = pos - cp;
                exp_d.push_back(dat(v));
                exp_l.push_back((idx == N - 1) || tl);
                if (idx == N - 1) begin
                    full++;
                    pos = 0;
                end else if (tl) begin
                    pos = 0;
                end else begin
                    pos++;
                end
            end
            v++;
        end
        in_limit = 0; toggle_cfg = 1'b0; s_if.tvalid = 1'b0;
        step();
        in_limit = v; next_val = 0; in_cnt = 0; out_cnt = 0;
        done_cnt = 0; done_cyc = -1; last_out_cyc = -1; prev_stall = 1'b0;
        vprob = vp; rprob = rp;
        m_if.tready  = 1'b1;
        s_if.tdata   = dat(0);
        s_if.tlast   = tl_of(0);
        nfft         = n[4:0];
        cp_len       = cp[CP_W-1:0];
        symbols      = SYM_W'(syms);
        continuous   = cont;
        config_start = 1'b1;
        step();
        check("arm_busy",      64'(busy),      64'd1);
        check("arm_sym_count", 64'(sym_count), 64'd0);
        budget = 20 * in_limit + 100;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            toggle_cfg = finite ? (out_cnt < (syms - 1) * N) : 1'b1;
            step();
            if (abort_at > 0) ok = (out_cnt >= abort_at);
            else if (finite)  ok = (done_cnt > 0);
            else              ok = (in_cnt == in_limit) && (exp_d.size() == 0);
        end
        toggle_cfg = 1'b0;
        check("run_timeout", 64'(ok), 64'd1);
        if (abort_at > 0) return;
        repeat (8) step();
        check("left_expected", 64'(exp_d.size()), 64'd0);
        check("in_count",      64'(in_cnt),        64'(in_limit));
        check("sym_count",     64'(sym_count),     64'(full));
        if (finite) begin
            check("done_count",   64'(done_cnt),                64'd1);
            check("done_latency", 64'(done_cyc - last_out_cyc), 64'd1);
            check("busy_end",     64'(busy),                    64'd0);
            check("s_ready_idle", 64'(s_if.tready),             64'd0);
        end else begin
            check("no_done",      64'(done_cnt), 64'd0);
            check("busy_running", 64'(busy),     64'd1);
        end
`ifdef CP_REMOVE_FRAME_CHECK_EN
        check("frame_err", 64'(frame_err), 64'(etl >= 0));
`endif
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        @(posedge aclk);
        #1;
        do_reset();

        run_stream(4, 4, 2, 1'b0, 0, 100, 100, 0, -1);
        run_stream(4, 4, 2, 1'b0, 0, 100, -1,  0, -1);
        run_stream(3, 0, 3, 1'b0, 0, 100, 100, 0, -1);
        run_stream(2, 9, 2, 1'b0, 0, 70,  60,  0, -1);
        for (int k = 0; k < 4; k++) begin
            run_stream($urandom_range(1, 5), $urandom_range(0, 20), $urandom_range(1, 4),
                       1'b0, 0, 60, 70, 0, -1);
        end

        run_stream(2, 3, 0, 1'b0, 200, 80, 80, 0, -1);
        do_reset();
        run_stream(4, 2, 0, 1'b1, 1000, 100, 100, 0, -1);
        do_reset();

        run_stream(4, 4, 2, 1'b0, 0, 100, 100, 26, -1);
        do_reset();
        run_stream(4, 4, 2, 1'b0, 0, 100, 100, 0, -1);

`ifdef CP_REMOVE_FRAME_CHECK_EN
        run_stream(4, 4, 2, 1'b0, 0, 100, 100, 0, 12);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
